// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with a shared
// bidirectional data bus. Each access runs IDLE -> ADDR -> ACCESS -> DONE.
module ram_arbiter #(
    parameter int awidth = 8,
    parameter int dwidth = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [awidth-1:0] addr0,
    input  logic [awidth-1:0] addr1,
    input  logic [dwidth-1:0] wdata0,
    input  logic [dwidth-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [dwidth-1:0] rdata0,
    output logic [dwidth-1:0] rdata1,
    output logic [awidth-1:0] address,
    inout  wire  [dwidth-1:0] data,
    output logic              write_enable
);

    typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_t;

    state_t            state_reg, state_next;
    logic              owner_reg;
    logic              last_reg;
    logic              we_reg;
    logic [awidth-1:0] addr_reg;
    logic [dwidth-1:0] wdata_reg;

    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [awidth-1:0] addr_vec  [2];
    logic [dwidth-1:0] wdata_vec [2];
    logic [dwidth-1:0] rdata_reg [2];
    logic [1:0]        ack_vec;
    logic              any_req;
    logic              grant;
    logic              drive_bus;

    assign req_vec      = {req1, req0};
    assign we_vec       = {we1, we0};
    assign addr_vec[0]  = addr0;
    assign addr_vec[1]  = addr1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;

    // Under contention the requester that did not win last time gets the grant.
    always_comb begin
        any_req = |req_vec;
        grant   = (req_vec == 2'b11) ? ~last_reg : req_vec[1];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req) state_next = ADDR;
            ADDR:    state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            last_reg  <= 1'b1;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && any_req) begin
                owner_reg <= grant;
                last_reg  <= grant;
                we_reg    <= we_vec[grant];
                addr_reg  <= addr_vec[grant];
                wdata_reg <= wdata_vec[grant];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            // Read data is sampled off the bus as the RAM drives it in ACCESS.
            always_ff @(posedge clk) begin
                if (!reset_n)
                    rdata_reg[gi] <= '0;
                else if (state_reg == ACCESS && !we_reg && owner_reg == 1'(gi))
                    rdata_reg[gi] <= data;
            end
            assign ack_vec[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign ack0   = ack_vec[0];
    assign ack1   = ack_vec[1];
    assign rdata0 = rdata_reg[0];
    assign rdata1 = rdata_reg[1];

    assign drive_bus    = (state_reg != IDLE) && we_reg;
    assign address      = (state_reg != IDLE) ? addr_reg : '0;
    assign write_enable = (state_reg == ACCESS) && we_reg;
    assign data         = drive_bus ? wdata_reg : {dwidth{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter with a small RAM model on the shared bus.
// The bench can drive probe patterns onto the bus to confirm the arbiter releases it.
module tb_ram_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    wire         ack0, ack1;
    wire  [15:0] rdata0, rdata1;
    wire  [7:0]  address;
    wire  [15:0] data;
    wire         write_enable;

    logic        ram_oe;
    logic [15:0] ram_q;
    logic [15:0] mem [256];

    int total;
    int bad;

    assign data = ram_oe ? ram_q : 16'hzzzz;

    always @(posedge clk) if (write_enable) mem[address] <= data;

    ram_arbiter #(.awidth(8), .dwidth(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .address(address), .data(data), .write_enable(write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives two complementary patterns; the bus only reads them back cleanly when nothing else drives it.
    task automatic bus_free(output bit ok);
        ok = 1'b1;
        ram_oe = 1'b1;
        ram_q  = 16'hA5A5;
        #1;
        if (data !== 16'hA5A5) ok = 1'b0;
        ram_q = 16'h5A5A;
        #1;
        if (data !== 16'h5A5A) ok = 1'b0;
        ram_oe = 1'b0;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 16'h0000; wdata1 = 16'h0000;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        idle_inputs();
        apply_reset();
        total++;
        if ({ack1, ack0, write_enable} !== 3'b000) begin
            bad++; $display("FAIL reset_ctrl: ack1/ack0/we=%b expected 000", {ack1, ack0, write_enable});
        end
        total++;
        if (address !== 8'h00) begin
            bad++; $display("FAIL reset_addr: address=%h expected 00", address);
        end
        total++;
        if (rdata0 !== 16'h0000 || rdata1 !== 16'h0000) begin
            bad++; $display("FAIL reset_rdata: rdata0=%h rdata1=%h expected 0000 0000", rdata0, rdata1);
        end
        bus_free(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL reset_bus: data bus driven by dut, expected high-Z");
        end
        $display("reset: checked outputs after reset");
    endtask

    task automatic test_write();
        req0 = 1; we0 = 1; addr0 = 8'h12; wdata0 = 16'hBEEF;
        tick();  // ADDR
        total++;
        if (address !== 8'h12 || data !== 16'hBEEF || write_enable !== 1'b0 || ack0 !== 1'b0) begin
            bad++; $display("FAIL write_addr: address=%h data=%h we=%b ack0=%b expected 12 BEEF 0 0",
                            address, data, write_enable, ack0);
        end
        tick();  // ACCESS
        total++;
        if (address !== 8'h12 || data !== 16'hBEEF || write_enable !== 1'b1 || ack0 !== 1'b0) begin
            bad++; $display("FAIL write_access: address=%h data=%h we=%b ack0=%b expected 12 BEEF 1 0",
                            address, data, write_enable, ack0);
        end
        tick();  // DONE
        total++;
        if ({ack1, ack0} !== 2'b01 || write_enable !== 1'b0) begin
            bad++; $display("FAIL write_ack: ack1/ack0=%b we=%b expected 01 0", {ack1, ack0}, write_enable);
        end
        req0 = 0; we0 = 0;
        tick();  // IDLE
        total++;
        if ({ack1, ack0} !== 2'b00 || address !== 8'h00 || mem[8'h12] !== 16'hBEEF) begin
            bad++; $display("FAIL write_end: acks=%b address=%h ram=%h expected 00 00 BEEF",
                            {ack1, ack0}, address, mem[8'h12]);
        end
        $display("write: addr=12 data=BEEF");
    endtask

    task automatic test_read();
        bit ok;
        req1 = 1; we1 = 0; addr1 = 8'h12;
        tick();  // ADDR
        bus_free(ok);
        total++;
        if (!ok || address !== 8'h12) begin
            bad++; $display("FAIL read_addr: bus_free=%0d address=%h expected 1 12", ok, address);
        end
        tick();  // ACCESS: RAM model drives the bus
        total++;
        if (write_enable !== 1'b0 || address !== 8'h12) begin
            bad++; $display("FAIL read_access: we=%b address=%h expected 0 12", write_enable, address);
        end
        ram_q  = mem[address];
        ram_oe = 1'b1;
        tick();  // DONE
        ram_oe = 1'b0;
        total++;
        if ({ack1, ack0} !== 2'b10 || rdata1 !== 16'hBEEF || rdata0 !== 16'h0000) begin
            bad++; $display("FAIL read_done: acks=%b rdata1=%h rdata0=%h expected 10 BEEF 0000",
                            {ack1, ack0}, rdata1, rdata0);
        end
        bus_free(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL read_bus: data bus driven by dut during read");
        end
        req1 = 0;
        tick();
        $display("read: addr=12 rdata1=%h", rdata1);
    endtask

    task automatic test_contention();
        logic [1:0] exp;
        idle_inputs();
        reset_n = 1'b0;
        req0 = 1; req1 = 1; addr0 = 8'h40; addr1 = 8'h41;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp = 2'b00;
            if (k % 4 == 2) exp = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
            total++;
            if ({ack1, ack0} !== exp) begin
                bad++; $display("FAIL contention_c%0d: ack1/ack0=%b expected %b", k, {ack1, ack0}, exp);
            end
        end
        idle_inputs();
        tick();
        $display("contention: 16 cycles of alternating grants");
    endtask

    task automatic test_midchange();
        apply_reset();
        req0 = 1; we0 = 1; addr0 = 8'h05; wdata0 = 16'h1234;
        tick();  // ADDR
        addr0 = 8'h06; wdata0 = 16'hFFFF;
        tick();  // ACCESS
        total++;
        if (address !== 8'h05 || data !== 16'h1234 || write_enable !== 1'b1) begin
            bad++; $display("FAIL midchange_access: address=%h data=%h we=%b expected 05 1234 1",
                            address, data, write_enable);
        end
        req0 = 0;
        tick();  // DONE, request already dropped
        total++;
        if ({ack1, ack0} !== 2'b01 || address !== 8'h05) begin
            bad++; $display("FAIL midchange_ack: acks=%b address=%h expected 01 05", {ack1, ack0}, address);
        end
        idle_inputs();
        tick();
        total++;
        if (mem[8'h05] !== 16'h1234) begin
            bad++; $display("FAIL midchange_ram: ram[05]=%h expected 1234", mem[8'h05]);
        end
        $display("midchange: access stayed at addr=05");
    endtask

    task automatic test_reset_mid_access();
        bit ok;
        req0 = 1; we0 = 1; addr0 = 8'h30; wdata0 = 16'hAAAA;
        tick();  // ADDR
        tick();  // ACCESS
        total++;
        if (write_enable !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre: we=%b expected 1", write_enable);
        end
        reset_n = 1'b0;
        idle_inputs();
        tick();
        reset_n = 1'b1;
        bus_free(ok);
        total++;
        if (!ok || write_enable !== 1'b0 || {ack1, ack0} !== 2'b00 || address !== 8'h00) begin
            bad++; $display("FAIL rstmid_abort: bus_free=%0d we=%b acks=%b address=%h expected 1 0 00 00",
                            ok, write_enable, {ack1, ack0}, address);
        end
        tick();
        total++;
        if ({ack1, ack0} !== 2'b00) begin
            bad++; $display("FAIL rstmid_noack: acks=%b expected 00", {ack1, ack0});
        end
        req0 = 1; req1 = 1; addr0 = 8'h50; addr1 = 8'h51;
        tick();
        tick();
        tick();  // DONE of the first post-reset grant
        total++;
        if ({ack1, ack0} !== 2'b01 || address !== 8'h50) begin
            bad++; $display("FAIL rstmid_priority: acks=%b address=%h expected 01 50", {ack1, ack0}, address);
        end
        idle_inputs();
        tick();
        $display("reset_mid_access: aborted write, requester 0 served next");
    endtask

    task automatic test_idle();
        bit ok;
        idle_inputs();
        for (int k = 0; k < 20; k++) begin
            tick();
            total++;
            if ({write_enable, ack1, ack0} !== 3'b000 || address !== 8'h00) begin
                bad++; $display("FAIL idle_c%0d: we/ack1/ack0=%b address=%h expected 000 00",
                                k, {write_enable, ack1, ack0}, address);
            end
        end
        bus_free(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL idle_bus: data bus driven by dut while idle");
        end
        $display("idle: 20 quiet cycles");
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        ram_oe  = 1'b0;
        ram_q   = 16'h0000;
        reset_n = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_midchange();
        test_reset_mid_access();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
